// File: rtl/bshifter_l32_pipe_if.sv
// Handshake/data bundle for the pipelined 32-bit left barrel shifter.
// master = operand producer / result consumer, slave = the shifter itself.
// Optional build macro: BSHIFTER_L32_ROTATE_EN adds the in_rot operand bit.
interface bshifter_l32_pipe_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      in_amount;
  logic [TAG_W-1:0] in_tag;
`ifdef BSHIFTER_L32_ROTATE_EN
  logic             in_rot;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_cf;
  logic             out_cf_upd;
  logic             out_zf;
  logic [TAG_W-1:0] out_tag;

`ifdef BSHIFTER_L32_ROTATE_EN
  modport master (
    output in_valid, in_data, in_amount, in_tag, in_rot, out_ready,
    input  in_ready, out_valid, out_data, out_cf, out_cf_upd, out_zf, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_amount, in_tag, in_rot, out_ready,
    output in_ready, out_valid, out_data, out_cf, out_cf_upd, out_zf, out_tag
  );
`else
  modport master (
    output in_valid, in_data, in_amount, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_cf, out_cf_upd, out_zf, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_amount, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_cf, out_cf_upd, out_zf, out_tag
  );
`endif
endinterface

// File: rtl/bshifter_l32_pipe.sv
// Pipelined 32-bit logical left barrel shifter (SHL) with x86-style CF/ZF.
// Five registered log stages (shift by 1,2,4,8,16) followed by an output
// register; the whole pipe advances only when the output can move.
// Optional build macro: BSHIFTER_L32_ROTATE_EN adds rotate-left (ROL) via in_rot.
module bshifter_l32_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  bshifter_l32_pipe_if.slave bus
);

  localparam int unsigned NSTG = 5;

  // per-stage pipeline registers
  logic [31:0]      data_q [NSTG];
  logic [31:0]      data_d [NSTG];
  logic             cf_q   [NSTG];
  logic             cf_d   [NSTG];
  logic [4:0]       amt_q  [NSTG];
  logic [4:0]       amt_d  [NSTG];
  logic             upd_q  [NSTG];
  logic             upd_d  [NSTG];
  logic             rot_q  [NSTG];
  logic             rot_d  [NSTG];
  logic             vld_q  [NSTG];
  logic             vld_d  [NSTG];
  logic [TAG_W-1:0] tag_q  [NSTG];
  logic [TAG_W-1:0] tag_d  [NSTG];

  // output register
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_cf_q, out_cf_d;
  logic             out_cf_upd_q, out_cf_upd_d;
  logic             out_zf_q, out_zf_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // stage input selection (operand port for stage 0, previous register otherwise)
  logic [31:0]      src_data;
  logic             src_cf;
  logic [4:0]       src_amt;
  logic             src_upd;
  logic             src_rot;
  logic             src_vld;
  logic [TAG_W-1:0] src_tag;
  logic [31:0]      sh;
  logic [4:0]       cf_idx;

  logic             rot_in;
  logic             advance;

`ifdef BSHIFTER_L32_ROTATE_EN
  assign rot_in = bus.in_rot;
`else
  assign rot_in = 1'b0;
`endif

  // whole pipe moves together whenever the output slot is free or being drained
  assign advance      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_cf     = out_cf_q;
  assign bus.out_cf_upd = out_cf_upd_q;
  assign bus.out_zf     = out_zf_q;
  assign bus.out_tag    = out_tag_q;

  // next-state for each log stage: stage k shifts by 2^k when its amount bit is set.
  // The amount is stored pre-shifted so bit 0 is always the current stage's control bit.
  always_comb begin
    src_data = '0;
    src_cf   = 1'b0;
    src_amt  = '0;
    src_upd  = 1'b0;
    src_rot  = 1'b0;
    src_vld  = 1'b0;
    src_tag  = '0;
    sh       = '0;
    cf_idx   = '0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      if (k == 0) begin
        src_data = bus.in_data;
        src_cf   = 1'b0;
        src_amt  = bus.in_amount[4:0];
        src_upd  = |bus.in_amount[4:0];
        src_rot  = rot_in;
        src_vld  = bus.in_valid;
        src_tag  = bus.in_tag;
      end else begin
        src_data = data_q[k-1];
        src_cf   = cf_q[k-1];
        src_amt  = amt_q[k-1];
        src_upd  = upd_q[k-1];
        src_rot  = rot_q[k-1];
        src_vld  = vld_q[k-1];
        src_tag  = tag_q[k-1];
      end
      sh     = 32'd1 << k;
      cf_idx = 5'(32 - sh);

      data_d[k] = src_data;
      cf_d[k]   = src_cf;
      if (src_amt[0]) begin
        // the last bit to leave [31] at this stage is the one at 32-2^k
        cf_d[k] = src_data[cf_idx];
        if (src_rot) begin
          data_d[k] = (src_data << sh) | (src_data >> (32 - sh));
        end else begin
          data_d[k] = src_data << sh;
        end
      end
      amt_d[k] = src_amt >> 1;
      upd_d[k] = src_upd;
      rot_d[k] = src_rot;
      vld_d[k] = src_vld;
      tag_d[k] = src_tag;
    end
  end

  // output stage: flags derived from the final stage result.
  // For rotate the CF chain already equals result bit 0 (the last bit to wrap).
  always_comb begin
    out_valid_d  = vld_q[NSTG-1];
    out_data_d   = data_q[NSTG-1];
    out_cf_d     = cf_q[NSTG-1];
    out_cf_upd_d = upd_q[NSTG-1];
    out_zf_d     = (data_q[NSTG-1] == '0);
    out_tag_d    = tag_q[NSTG-1];
  end

  // pipeline and output registers, flushed by reset, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        data_q[k] <= '0;
        cf_q[k]   <= 1'b0;
        amt_q[k]  <= '0;
        upd_q[k]  <= 1'b0;
        rot_q[k]  <= 1'b0;
        vld_q[k]  <= 1'b0;
        tag_q[k]  <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cf_q     <= 1'b0;
      out_cf_upd_q <= 1'b0;
      out_zf_q     <= 1'b0;
      out_tag_q    <= '0;
    end else if (advance) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        data_q[k] <= data_d[k];
        cf_q[k]   <= cf_d[k];
        amt_q[k]  <= amt_d[k];
        upd_q[k]  <= upd_d[k];
        rot_q[k]  <= rot_d[k];
        vld_q[k]  <= vld_d[k];
        tag_q[k]  <= tag_d[k];
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cf_q     <= out_cf_d;
      out_cf_upd_q <= out_cf_upd_d;
      out_zf_q     <= out_zf_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_bshifter_l32_pipe.sv
// Self-checking bench for bshifter_l32_pipe: directed cases, randomized
// amount sweep with backpressure, stall ordering and mid-flight reset.
module tb_bshifter_l32_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bshifter_l32_pipe_if #(.TAG_W(4)) bus ();

  bshifter_l32_pipe #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        cf;
    logic        upd;
    logic        zf;
    logic [3:0]  tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic hold_pend = 1'b0;
  exp_t hold;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // reference: plain arithmetic on the 5-bit amount
  function automatic exp_t model(input logic [31:0] d, input logic [31:0] amt,
                                 input logic rot, input logic [3:0] tag);
    exp_t        r;
    int unsigned a;
    a = amt & 32'd31;
    if (a == 0) begin
      r.data = d;
      r.cf   = 1'b0;
    end else begin
      r.data = rot ? ((d << a) | (d >> (32 - a))) : (d << a);
      r.cf   = d[32 - a];
    end
    r.upd = (a != 0);
    r.zf  = (r.data == 32'd0);
    r.tag = tag;
    return r;
  endfunction

  // one clock cycle: drive inputs, check any result transfer and stall hold, record acceptance
  task automatic cycle(input logic v, input logic [31:0] d, input logic [31:0] amt,
                       input logic [3:0] tag, input logic rot, input logic ordy,
                       output logic acc, output logic got, output exp_t obs);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amount = amt;
    bus.in_tag    = tag;
`ifdef BSHIFTER_L32_ROTATE_EN
    bus.in_rot    = rot;
`endif
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    got = 1'b0;
    obs = {bus.out_data, bus.out_cf, bus.out_cf_upd, bus.out_zf, bus.out_tag};
    if (hold_pend) begin
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_data", bus.out_data, hold.data);
      check("hold_flags", {29'd0, bus.out_cf, bus.out_cf_upd, bus.out_zf},
            {29'd0, hold.cf, hold.upd, hold.zf});
      check("hold_tag", {28'd0, bus.out_tag}, {28'd0, hold.tag});
    end
    if (bus.out_valid && ordy) begin
      got = 1'b1;
      if (q.size() == 0) begin
        check("spurious_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("res_data", bus.out_data, e.data);
        check("res_cf", {31'd0, bus.out_cf}, {31'd0, e.cf});
        check("res_cf_upd", {31'd0, bus.out_cf_upd}, {31'd0, e.upd});
        check("res_zf", {31'd0, bus.out_zf}, {31'd0, e.zf});
        check("res_tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
      end
    end
    hold_pend = bus.out_valid && !ordy;
    hold      = obs;
    if (v && bus.in_ready) begin
      acc = 1'b1;
      q.push_back(model(d, amt, rot, tag));
    end
  endtask

  task automatic drain();
    logic a, g;
    exp_t o;
    for (int i = 0; i < 30 && q.size() > 0; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, a, g, o);
    check("drain_empty", q.size(), 32'd0);
  endtask

  // single op against fixed expected values, with latency measurement
  task automatic directed(input logic [31:0] d, input logic [31:0] amt, input logic rot,
                          input logic [31:0] ed, input logic ecf, input logic eupd, input logic ezf);
    logic a, g, seen;
    exp_t o;
    seen = 1'b0;
    cycle(1'b1, d, amt, 4'h5, rot, 1'b1, a, g, o);
    check("dir_accept", {31'd0, a}, 32'd1);
    for (int j = 1; j <= 10 && !seen; j++) begin
      cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, a, g, o);
      if (g) begin
        seen = 1'b1;
        check("dir_latency", j, 32'd6);
        check("dir_data", o.data, ed);
        check("dir_cf", {31'd0, o.cf}, {31'd0, ecf});
        check("dir_cf_upd", {31'd0, o.upd}, {31'd0, eupd});
        check("dir_zf", {31'd0, o.zf}, {31'd0, ezf});
      end
    end
    check("dir_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a, g, rv, ordy;
    exp_t        o;
    int          nxt, exp_tag, c;
    logic [31:0] amt;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_tag    = '0;
`ifdef BSHIFTER_L32_ROTATE_EN
    bus.in_rot    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_flags", {29'd0, bus.out_cf, bus.out_cf_upd, bus.out_zf}, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);

    // directed boundary cases
    directed(32'h0000_0001, 32'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(32'h8000_0001, 32'd1,  1'b0, 32'h0000_0002, 1'b1, 1'b1, 1'b0);
    directed(32'h8000_0001, 32'd32, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    directed(32'h8000_0001, 32'd33, 1'b0, 32'h0000_0002, 1'b1, 1'b1, 1'b0);
    directed(32'hF000_0000, 32'd4,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    directed(32'h1234_5678, 32'd0,  1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
`ifdef BSHIFTER_L32_ROTATE_EN
    directed(32'h8000_0001, 32'd4, 1'b1, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
    directed(32'h8000_0001, 32'd1, 1'b1, 32'h0000_0003, 1'b1, 1'b1, 1'b0);
`endif

    // randomized sweep of every amount, random high amount bits, bubbles and backpressure
    for (int pass = 0; pass < 3; pass++) begin
      for (int s = 0; s < 32; s++) begin
        rv = 1'b0;
`ifdef BSHIFTER_L32_ROTATE_EN
        rv = 1'($urandom_range(0, 1));
`endif
        amt  = ($urandom() & 32'hFFFF_FFE0) | 32'(s);
        ordy = ($urandom_range(0, 3) != 0);
        do begin
          cycle(1'b1, $urandom(), amt, 4'(s), rv, ordy, a, g, o);
          ordy = ($urandom_range(0, 3) != 0);
        end while (!a);
        if ($urandom_range(0, 4) == 0) cycle(1'b0, $urandom(), $urandom(), '0, 1'b0, ordy, a, g, o);
      end
      drain();
    end

    // 8 back-to-back ops, consumer stalls for cycles 6..9
    nxt = 0;
    exp_tag = 0;
    c = 0;
    while (c < 60 && (nxt < 8 || q.size() > 0)) begin
      ordy = !(c >= 6 && c <= 9);
      cycle(nxt < 8, $urandom(), $urandom(), 4'(nxt), 1'b0, ordy, a, g, o);
      if (c >= 6 && c <= 9) check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (a) nxt++;
      if (g) begin
        check("stall_order", {28'd0, o.tag}, 32'(exp_tag));
        exp_tag++;
      end
      c++;
    end
    check("stall_count", exp_tag, 32'd8);
    drain();

    // three ops in flight, then reset flushes them
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom(), $urandom(), 4'(i), 1'b0, 1'b1, a, g, o);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    q.delete();
    hold_pend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, a, g, o);
      check("flush_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end

    // pipe works normally after the flush
    directed(32'h0000_00FF, 32'd8, 1'b0, 32'h0000_FF00, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
